// File: rtl/alu_control_pipe.sv
// Registered, handshaked ALU-control decoder with multi-cycle mul/div sequencing.
// Define ALU_CTRL_MULDIV_EN to decode mul/div (funct 08/09) as multi-cycle ops held in BUSY.
module alu_control_pipe #(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ALUCNT_W   = 4,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUCNT_W-1:0] alucnt,
  output logic                illegal,
  output logic                multicycle,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StValid, StBusy} state_e;

  state_e              state_q;
  logic                out_valid_q;
  logic [ALUCNT_W-1:0] alucnt_q;
  logic                illegal_q;

  logic [ALUOP_W-1:0]  aluop_hi;
  logic [FUNCT_W-1:0]  funct_hi;
  logic [2:0]          aluop_lo;
  logic [5:0]          funct_lo;
  logic [3:0]          dec_code;
  logic                dec_illegal;
  logic                accept;

`ifdef ALU_CTRL_MULDIV_EN
  localparam int unsigned CntW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

  logic                dec_mc;
  logic [CntW-1:0]     cnt_q;
  logic [3:0]          held_q;
  logic                busy_q;
  logic                multicycle_q;
`endif

  // Bits above the decoded field only need to be checked for zero.
  assign aluop_hi = aluop >> 3;
  assign funct_hi = funct >> 6;
  assign aluop_lo = aluop[2:0];
  assign funct_lo = funct[5:0];

  always_comb begin
    dec_code    = 4'b0000;
    dec_illegal = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
    dec_mc      = 1'b0;
`endif
    case (aluop_lo)
      3'b000: begin
        case (funct_lo)
          6'h00:   dec_code = 4'b0000;
          6'h01:   dec_code = 4'b0001;
          6'h02:   dec_code = 4'b0101;
          6'h03:   dec_code = 4'b0110;
          6'h04:   dec_code = 4'b0111;
          6'h05:   dec_code = 4'b0011;
          6'h06:   dec_code = 4'b0100;
          6'h07:   dec_code = 4'b0010;
`ifdef ALU_CTRL_MULDIV_EN
          6'h08: begin
            dec_code = 4'b1000;
            dec_mc   = 1'b1;
          end
          6'h09: begin
            dec_code = 4'b1001;
            dec_mc   = 1'b1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b001:  dec_code = 4'b0001;
      3'b010:  dec_code = 4'b0111;
      3'b011:  dec_code = 4'b0000;
      3'b100:  dec_code = 4'b0011;
      default: dec_illegal = 1'b1;
    endcase
    if ((|aluop_hi) || (|funct_hi)) begin
      dec_code    = 4'b0000;
      dec_illegal = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
      dec_mc      = 1'b0;
`endif
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        StIdle:  in_ready = 1'b1;
        StValid: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // accept can only fire in IDLE or VALID, so loads are handled ahead of the state case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      alucnt_q     <= '0;
      illegal_q    <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
      cnt_q        <= '0;
      held_q       <= 4'b0000;
      busy_q       <= 1'b0;
      multicycle_q <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_CTRL_MULDIV_EN
      if (dec_mc) begin
        // Loading LATENCY-1 puts out_valid exactly MC_LATENCY edges after the accept.
        state_q     <= StBusy;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
        held_q      <= dec_code;
        cnt_q       <= CntW'(MC_LATENCY - 1);
      end else begin
        state_q      <= StValid;
        out_valid_q  <= 1'b1;
        alucnt_q     <= ALUCNT_W'(dec_code);
        illegal_q    <= dec_illegal;
        multicycle_q <= 1'b0;
      end
`else
      state_q     <= StValid;
      out_valid_q <= 1'b1;
      alucnt_q    <= ALUCNT_W'(dec_code);
      illegal_q   <= dec_illegal;
`endif
    end else begin
      case (state_q)
        StValid: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_CTRL_MULDIV_EN
        StBusy: begin
          if (cnt_q == '0) begin
            state_q      <= StValid;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
            alucnt_q     <= ALUCNT_W'(held_q);
            illegal_q    <= 1'b0;
            multicycle_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign alucnt    = alucnt_q;
  assign illegal   = illegal_q;

`ifdef ALU_CTRL_MULDIV_EN
  assign busy       = busy_q;
  assign multicycle = multicycle_q;
`else
  assign busy       = 1'b0;
  assign multicycle = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Testbench for alu_control_pipe: directed vectors plus a transaction-level reference model
// checked on every cycle. Mul/div cases run only when ALU_CTRL_MULDIV_EN is defined.
module tb_alu_control_pipe;

  localparam int unsigned MC_LATENCY = 4;

  localparam logic [3:0] R_LUT [8]  = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h3, 4'h4, 4'h2};
  localparam logic [3:0] OP_LUT [5] = '{4'h0, 4'h1, 4'h7, 4'h0, 4'h3};
  localparam logic [3:0] EXP_STREAM [8] = '{4'b0000, 4'b0001, 4'b0101, 4'b0110,
                                           4'b0111, 4'b0011, 4'b0100, 4'b0010};
  localparam logic [3:0] EXP_OPS [4] = '{4'b0001, 4'b0111, 4'b0000, 4'b0011};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] aluop;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alucnt;
  logic       illegal;
  logic       multicycle;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_control_pipe #(
    .ALUOP_W   (3),
    .FUNCT_W   (6),
    .ALUCNT_W  (4),
    .MC_LATENCY(MC_LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alucnt    (alucnt),
    .illegal   (illegal),
    .multicycle(multicycle),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: output slot plus a pending mul/div result that surfaces after N edges.
  bit         chk_en = 1'b0;
  logic       m_ov = 1'b0, m_ill = 1'b0, m_mc = 1'b0, m_busy = 1'b0;
  logic [3:0] m_cnt = 4'h0, m_held = 4'h0;
  int         m_pend = 0;

  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output logic ill,
                                     output logic mc);
    code = 4'h0;
    ill  = 1'b0;
    mc   = 1'b0;
    if (op == 3'd0 && fn < 6'd8) code = R_LUT[fn[2:0]];
`ifdef ALU_CTRL_MULDIV_EN
    else if (op == 3'd0 && (fn == 6'd8 || fn == 6'd9)) begin
      code = fn[3:0];
      mc   = 1'b1;
    end
`endif
    else if (op >= 3'd1 && op <= 3'd4) code = OP_LUT[op];
    else ill = 1'b1;
  endfunction

  function automatic logic exp_ready();
    return rst_n && (m_pend == 0) && (!m_ov || out_ready);
  endfunction

  always @(posedge clk) begin : model
    logic       acc;
    logic [3:0] c;
    logic       il;
    logic       mcx;
    acc = in_valid && exp_ready();
    if (!rst_n) begin
      m_ov = 1'b0; m_ill = 1'b0; m_mc = 1'b0; m_busy = 1'b0; m_cnt = 4'h0; m_pend = 0;
      chk_en = 1'b1;
    end else if (acc) begin
      ref_decode(aluop, funct, c, il, mcx);
      if (mcx) begin
        m_pend = MC_LATENCY; m_held = c; m_ov = 1'b0; m_busy = 1'b1;
      end else begin
        m_ov = 1'b1; m_cnt = c; m_ill = il; m_mc = 1'b0;
      end
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_ov = 1'b1; m_cnt = m_held; m_ill = 1'b0; m_mc = 1'b1; m_busy = 1'b0;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      chk("m_in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("m_alucnt", 32'(alucnt), 32'(m_cnt));
      chk("m_illegal", 32'(illegal), 32'(m_ill));
      chk("m_multicycle", 32'(multicycle), 32'(m_mc));
      chk("m_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; aluop = 3'd0; funct = 6'd0;

    // Reset
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alucnt", 32'(alucnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back R-type stream
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      aluop = 3'd0; funct = 6'(i); in_valid = 1'b1;
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_alucnt", 32'(alucnt), 32'(EXP_STREAM[i]));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0; funct = 6'h02; in_valid = 1'b1;
    tick();
    funct = 6'h03;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_alucnt", 32'(alucnt), 32'b0101);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_next_alucnt", 32'(alucnt), 32'b0110);
    in_valid = 1'b0;
    tick();

    // Illegal encodings and non-R-type classes
    aluop = 3'b101; funct = 6'h00; in_valid = 1'b1;
    tick();
    chk("ill_op_flag", 32'(illegal), 32'd1);
    chk("ill_op_alucnt", 32'(alucnt), 32'd0);
    chk("ill_op_valid", 32'(out_valid), 32'd1);
    aluop = 3'b000; funct = 6'h3F;
    tick();
    chk("ill_fn_flag", 32'(illegal), 32'd1);
    chk("ill_fn_alucnt", 32'(alucnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      aluop = 3'(i + 1); funct = 6'h3F;
      tick();
      chk("op_alucnt", 32'(alucnt), 32'(EXP_OPS[i]));
      chk("op_illegal", 32'(illegal), 32'd0);
    end
`ifndef ALU_CTRL_MULDIV_EN
    aluop = 3'b000; funct = 6'h08;
    tick();
    chk("nomd_mul_ill", 32'(illegal), 32'd1);
    funct = 6'h09;
    tick();
    chk("nomd_div_ill", 32'(illegal), 32'd1);
    chk("nomd_div_busy", 32'(busy), 32'd0);
`endif
    in_valid = 1'b0;
    tick();

`ifdef ALU_CTRL_MULDIV_EN
    // Multi-cycle div: busy for edges k..k+3, result at k+4
    aluop = 3'b000; funct = 6'h09; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mc_busy_k", 32'(busy), 32'd1);
    chk("mc_valid_k", 32'(out_valid), 32'd0);
    chk("mc_ready_k", 32'(in_ready), 32'd0);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("mc_busy_hold", 32'(busy), 32'd1);
      chk("mc_valid_hold", 32'(out_valid), 32'd0);
    end
    tick();
    chk("mc_done_valid", 32'(out_valid), 32'd1);
    chk("mc_done_alucnt", 32'(alucnt), 32'b1001);
    chk("mc_done_mc", 32'(multicycle), 32'd1);
    chk("mc_done_busy", 32'(busy), 32'd0);
    tick();

    // Reset during BUSY aborts the op
    funct = 6'h08; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
`endif

    // Sweep of aluop/funct with irregular valid/ready patterns, checked by the model
    for (int i = 0; i < 128; i++) begin
      aluop     = 3'(i / 16);
      funct     = (i % 7 == 6) ? 6'h3F : 6'(i % 16);
      in_valid  = (i % 5) != 4;
      out_ready = (i % 3) != 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
